// File: rtl/p405s_timerwdctl.sv
// Watchdog sequencer: detects the selected time-base tap edge, walks ENW -> WIS -> reset,
// and holds the watchdog reset request for RST_HOLD cycles after escalation.
module p405s_timerwdctl #(
    parameter int RST_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       i_cb,
    input  logic       i_reset_core,
    input  logic [3:0] i_tb_wd_taps,
    input  logic [1:0] i_tcr_wp,
    input  logic [1:0] i_tcr_wrc,
    input  logic       i_tcr_wie,
    input  logic [1:0] i_timer_status,
    input  logic       i_dbg_freeze_timers,
    output logic       o_wd_pulse,
    output logic       o_hw_set_wd_intrp,
    output logic       o_hw_set_wd_rst,
    output logic [1:0] o_wd_rst_type,
    output logic [1:0] o_wd_rst_req,
    output logic       o_wd_intrp_req,
    output logic [1:0] o_dbg_state
);

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_RST_HOLD = 2'b01;
    localparam logic [1:0] ST_RST_DONE = 2'b10;

    localparam logic [CNT_W-1:0] LP_HOLD = CNT_W'(RST_HOLD);
    localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tap_prev;
    logic [1:0]       r_wp_prev;
    logic             r_wd_pulse;
    logic             r_hw_set_wd_intrp;
    logic             r_hw_set_wd_rst;
    logic [1:0]       r_wd_rst_type;
    logic             r_wd_intrp_req;

    logic w_tap;
    logic w_evt;
    logic w_enw;
    logic w_wis;
    logic w_escalate;

    assign w_tap = i_tb_wd_taps[i_tcr_wp];
    assign w_enw = i_timer_status[0];
    assign w_wis = i_timer_status[1];

    // A period-select change is never an edge, even if the newly selected tap is high.
    assign w_evt = w_tap & ~r_tap_prev & ~i_dbg_freeze_timers &
                   (i_tcr_wp == r_wp_prev) & (r_state == ST_IDLE);
    assign w_escalate = w_evt & w_enw & w_wis & (i_tcr_wrc != 2'b00);

    always_ff @(posedge i_cb or posedge i_reset_core) begin
        if (i_reset_core) begin
            r_tap_prev        <= 1'b1;
            r_wp_prev         <= 2'b00;
            r_wd_pulse        <= 1'b0;
            r_hw_set_wd_intrp <= 1'b0;
            r_hw_set_wd_rst   <= 1'b0;
            r_wd_intrp_req    <= 1'b0;
        end else begin
            r_tap_prev        <= w_tap;
            r_wp_prev         <= i_tcr_wp;
            r_wd_pulse        <= w_evt & ~w_enw;
            r_hw_set_wd_intrp <= w_evt & w_enw & ~w_wis;
            r_hw_set_wd_rst   <= w_escalate;
            r_wd_intrp_req    <= w_wis & i_tcr_wie;
        end
    end

    // Counter reaching 1 ends the hold, so the request is high exactly RST_HOLD cycles.
    always_ff @(posedge i_cb or posedge i_reset_core) begin
        if (i_reset_core) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_wd_rst_type <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_escalate) begin
                        r_state       <= ST_RST_HOLD;
                        r_cnt         <= LP_HOLD;
                        r_wd_rst_type <= i_tcr_wrc;
                    end
                end
                ST_RST_HOLD: begin
                    if (r_cnt == LP_ONE) begin
                        r_state <= ST_RST_DONE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - LP_ONE;
                    end
                end
                ST_RST_DONE: begin
                    r_state <= ST_RST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_wd_pulse        = r_wd_pulse;
    assign o_hw_set_wd_intrp = r_hw_set_wd_intrp;
    assign o_hw_set_wd_rst   = r_hw_set_wd_rst;
    assign o_wd_rst_type     = r_wd_rst_type;
    assign o_wd_rst_req      = (r_state == ST_RST_HOLD) ? r_wd_rst_type : 2'b00;
    assign o_wd_intrp_req    = r_wd_intrp_req;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_p405s_timerwdctl.sv
// Bench for the watchdog sequencer: a sequential vector table for the idle-state decisions,
// then hand sequences for escalation, hold length and reset during hold.
module tb_p405s_timerwdctl;

    logic       clk;
    logic       rst;
    logic [3:0] taps;
    logic [1:0] wp;
    logic [1:0] wrc;
    logic       wie;
    logic [1:0] tsr;
    logic       frz;
    logic       wd_pulse;
    logic       set_intrp;
    logic       set_rst;
    logic [1:0] rst_type;
    logic [1:0] rst_req;
    logic       intrp_req;
    logic [1:0] dbg_state;

    int n_chk;
    int n_fail;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_DONE = 2'b10;

    p405s_timerwdctl #(.RST_HOLD(8), .CNT_W(4)) dut (
        .i_cb               (clk),
        .i_reset_core       (rst),
        .i_tb_wd_taps       (taps),
        .i_tcr_wp           (wp),
        .i_tcr_wrc          (wrc),
        .i_tcr_wie          (wie),
        .i_timer_status     (tsr),
        .i_dbg_freeze_timers(frz),
        .o_wd_pulse         (wd_pulse),
        .o_hw_set_wd_intrp  (set_intrp),
        .o_hw_set_wd_rst    (set_rst),
        .o_wd_rst_type      (rst_type),
        .o_wd_rst_req       (rst_req),
        .o_wd_intrp_req     (intrp_req),
        .o_dbg_state        (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] taps;
        logic [1:0] wp;
        logic [1:0] wrc;
        logic       wie;
        logic [1:0] tsr;
        logic       frz;
        logic       e_pulse;
        logic       e_intrp;
        logic       e_rst;
        logic       e_intrp_req;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic [3:0] t, input logic [1:0] w, input logic [1:0] c,
                                input logic ie, input logic [1:0] s, input logic f,
                                input logic ep, input logic ei, input logic er, input logic eq);
        vec_t v;
        v.taps = t; v.wp = w; v.wrc = c; v.wie = ie; v.tsr = s; v.frz = f;
        v.e_pulse = ep; v.e_intrp = ei; v.e_rst = er; v.e_intrp_req = eq;
        return v;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] t, input logic [1:0] w, input logic [1:0] c,
                         input logic ie, input logic [1:0] s, input logic f);
        taps = t; wp = w; wrc = c; wie = ie; tsr = s; frz = f;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_no_strobe(input string name);
        chk({name, "_pulse"}, {3'b0, wd_pulse}, 4'h0);
        chk({name, "_intrp"}, {3'b0, set_intrp}, 4'h0);
        chk({name, "_rst"}, {3'b0, set_rst}, 4'h0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        drive(4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);

        // Sequential vectors; each expectation follows from the previous row's tap/wp.
        //              taps     wp     wrc    wie   tsr    frz   pls   int   rst   ireq
        vecs[0]  = mk(4'b0000, 2'd0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(4'b0001, 2'd0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(4'b0001, 2'd0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(4'b0000, 2'd0, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(4'b0001, 2'd0, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[5]  = mk(4'b0000, 2'd0, 2'b00, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[6]  = mk(4'b0001, 2'd0, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(4'b0000, 2'd0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(4'b0001, 2'd0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(4'b0000, 2'd0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(4'b0010, 2'd1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(4'b0000, 2'd1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[12] = mk(4'b0010, 2'd1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[13] = mk(4'b1000, 2'd3, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[14] = mk(4'b0000, 2'd3, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[15] = mk(4'b1000, 2'd3, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[16] = mk(4'b1000, 2'd3, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        tick();
        tick();
        rst = 1'b0;
        chk("rst_pulse", {3'b0, wd_pulse}, 4'h0);
        chk("rst_intrp", {3'b0, set_intrp}, 4'h0);
        chk("rst_rst", {3'b0, set_rst}, 4'h0);
        chk("rst_type", {2'b0, rst_type}, 4'h0);
        chk("rst_req", {2'b0, rst_req}, 4'h0);
        chk("rst_ireq", {3'b0, intrp_req}, 4'h0);
        chk("rst_state", {2'b0, dbg_state}, {2'b0, S_IDLE});

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].taps, vecs[i].wp, vecs[i].wrc, vecs[i].wie, vecs[i].tsr, vecs[i].frz);
            tick();
            chk($sformatf("vec%0d_pulse", i), {3'b0, wd_pulse}, {3'b0, vecs[i].e_pulse});
            chk($sformatf("vec%0d_intrp", i), {3'b0, set_intrp}, {3'b0, vecs[i].e_intrp});
            chk($sformatf("vec%0d_rst", i), {3'b0, set_rst}, {3'b0, vecs[i].e_rst});
            chk($sformatf("vec%0d_ireq", i), {3'b0, intrp_req}, {3'b0, vecs[i].e_intrp_req});
            chk($sformatf("vec%0d_req", i), {2'b0, rst_req}, 4'h0);
            chk($sformatf("vec%0d_state", i), {2'b0, dbg_state}, {2'b0, S_IDLE});
        end

        // Escalation to a chip reset, held for 8 cycles; WRC changes and freeze do not disturb it.
        do_reset();
        drive(4'b0000, 2'd1, 2'b10, 1'b0, 2'b11, 1'b0);
        tick();
        drive(4'b0010, 2'd1, 2'b10, 1'b0, 2'b11, 1'b0);
        tick();
        chk("esc_rst_strobe", {3'b0, set_rst}, 4'h1);
        chk("esc_pulse", {3'b0, wd_pulse}, 4'h0);
        chk("esc_intrp", {3'b0, set_intrp}, 4'h0);
        chk("esc_type", {2'b0, rst_type}, 4'h2);
        chk("esc_req_c1", {2'b0, rst_req}, 4'h2);
        for (int c = 2; c <= 8; c++) begin
            drive((c % 2 == 0) ? 4'b0000 : 4'b0010, 2'd1, 2'b01, 1'b0, 2'b11,
                  (c >= 3 && c <= 5) ? 1'b1 : 1'b0);
            tick();
            chk($sformatf("hold_req_c%0d", c), {2'b0, rst_req}, 4'h2);
            chk($sformatf("hold_strobe_c%0d", c), {3'b0, set_rst}, 4'h0);
        end
        drive(4'b0000, 2'd1, 2'b01, 1'b0, 2'b11, 1'b0);
        tick();
        chk("done_req", {2'b0, rst_req}, 4'h0);
        chk("done_type", {2'b0, rst_type}, 4'h2);
        chk("done_state", {2'b0, dbg_state}, {2'b0, S_DONE});
        for (int c = 0; c < 4; c++) begin
            drive((c % 2 == 0) ? 4'b0010 : 4'b0000, 2'd1, 2'b01, 1'b0, (c < 2) ? 2'b00 : 2'b11, 1'b0);
            tick();
            chk_no_strobe($sformatf("done_ign%0d", c));
            chk($sformatf("done_ign%0d_req", c), {2'b0, rst_req}, 4'h0);
        end

        // WRC=00 at full escalation: no action, stay idle.
        do_reset();
        drive(4'b0000, 2'd2, 2'b00, 1'b0, 2'b11, 1'b0);
        tick();
        drive(4'b0100, 2'd2, 2'b00, 1'b0, 2'b11, 1'b0);
        tick();
        chk_no_strobe("wrc0");
        chk("wrc0_req", {2'b0, rst_req}, 4'h0);
        chk("wrc0_state", {2'b0, dbg_state}, {2'b0, S_IDLE});

        // Reset asserted mid-hold drops the request without a clock edge.
        do_reset();
        drive(4'b0000, 2'd1, 2'b11, 1'b0, 2'b11, 1'b0);
        tick();
        drive(4'b0010, 2'd1, 2'b11, 1'b0, 2'b11, 1'b0);
        tick();
        chk("mid_req_before", {2'b0, rst_req}, 4'h3);
        drive(4'b0000, 2'd1, 2'b11, 1'b0, 2'b11, 1'b0);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_req_async", {2'b0, rst_req}, 4'h0);
        chk("mid_type_async", {2'b0, rst_type}, 4'h0);
        chk("mid_state_async", {2'b0, dbg_state}, {2'b0, S_IDLE});

        // Tap already high when reset releases is not an edge.
        drive(4'b0001, 2'd0, 2'b00, 1'b0, 2'b00, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk_no_strobe("tap_hi_oor1");
        tick();
        chk_no_strobe("tap_hi_oor2");
        drive(4'b0000, 2'd0, 2'b00, 1'b0, 2'b00, 1'b0);
        tick();
        drive(4'b0001, 2'd0, 2'b00, 1'b0, 2'b00, 1'b0);
        tick();
        chk("post_rst_pulse", {3'b0, wd_pulse}, 4'h1);
        tick();
        chk("post_rst_pulse_one", {3'b0, wd_pulse}, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
